atable_lookup_ram: RTL

Writable, parametrised NES attribute-table store with a pipelined palette lookup port. It holds one 64-byte attribute table per nametable (NTABLES of them) and is loaded by the CPU/PPU register side. It resolves a tile coordinate (nametable, column, row) into the 2-bit palette index for the background renderer. A self-clearing sequencer fills the memory with INIT_VAL after reset or on request.

---
 rtl/atable_lookup_ram.sv | 125 ++++++++++++
 1 files changed

// File: rtl/atable_lookup_ram.sv
// NES attribute-table store: NTABLES x 64-byte RAM with a self-clearing fill
// sequencer and a two-stage tile-to-palette lookup pipeline.
module atable_lookup_ram #(
  parameter int          NTABLES  = 1,
  parameter logic [7:0]  INIT_VAL = 8'h00,
  localparam int         NTW      = (NTABLES > 1) ? $clog2(NTABLES) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           wr_en,
  input  logic [NTW+5:0] wr_addr,
  input  logic [7:0]     wr_data,
  input  logic           rd_req,
  input  logic [NTW-1:0] rd_nt,
  input  logic [4:0]     rd_col,
  input  logic [4:0]     rd_row,
  output logic           rd_valid,
  output logic [1:0]     rd_pal,
  output logic [7:0]     rd_byte,
  output logic           busy
);

  localparam int DEPTH = NTABLES * 64;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state, state_d;
  logic [AW-1:0]   cnt, cnt_d;
  logic [7:0]      mem [DEPTH];

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [7:0]      mem_wdata;
  logic [NTW+5:0]  rd_addr_full;
  logic [AW-1:0]   rd_addr;
  logic            rd_ok;

  logic            s1_valid;
  logic [1:0]      s1_quad;
  logic [7:0]      s1_byte;
  logic [1:0]      pal_sel;

  // With a single table the table-select bits carry no information.
  logic unused_tbl_bits;
  generate
    if (NTABLES == 1) begin : g_one_table
      assign unused_tbl_bits = wr_addr[NTW+5] ^ rd_nt[0];
    end else begin : g_multi_table
      assign unused_tbl_bits = 1'b0;
    end
  endgenerate

  // NOTE: state is registered with non-blocking assignments only; the
  // next-state logic below computes values with blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // NOTE: defaults first, so every path assigns every output and no latch forms.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      CLEAR: begin
        cnt_d = cnt + AW'(1);
        if (cnt == AW'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign busy = (state == CLEAR);

  // The clear sequencer owns the single write port while it runs.
  assign mem_we    = busy | wr_en;
  assign mem_waddr = busy ? cnt : wr_addr[AW-1:0];
  assign mem_wdata = busy ? INIT_VAL : wr_data;

  assign rd_addr_full = {rd_nt, rd_row[4:2], rd_col[4:2]};
  assign rd_addr      = rd_addr_full[AW-1:0];
  assign rd_ok        = rd_req & ~busy;

  // NOTE: the RAM array and its read register are deliberately not reset so
  // they map onto block RAM; the valid pipeline decides what is meaningful.
  // Same-address read and write in one cycle returns the old byte.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_ok)  s1_byte <= mem[rd_addr];
  end

  assign pal_sel = s1_byte[{s1_quad, 1'b0} +: 2];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_quad  <= '0;
      rd_valid <= 1'b0;
      rd_pal   <= '0;
      rd_byte  <= '0;
    end else begin
      s1_valid <= rd_ok;
      if (rd_ok) s1_quad <= {rd_row[1], rd_col[1]};
      rd_valid <= s1_valid;
      if (s1_valid) begin
        rd_pal  <= pal_sel;
        rd_byte <= s1_byte;
      end
    end
  end

endmodule
